// File: rtl/weight_config_streamer.sv
// weight_config_streamer: drives the neuron weight-config broadcast bus from a valid/ready word stream.
// Optional load checksum accumulator is enabled by defining WEIGHT_CHECKSUM_EN.
module weight_config_streamer #(
  parameter int data_bits = 16,
  parameter int max_weights = 784,
  parameter int max_neurons = 64,
  localparam int wbits = $clog2(max_weights + 1),
  localparam int nbits = $clog2(max_neurons + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      cfg_layer_no,
  input  logic [nbits-1:0] cfg_neuron_count,
  input  logic [wbits-1:0] cfg_weight_count,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             weight_valid,
  output logic [31:0]      weight_value,
  output logic [31:0]      config_layer_no,
  output logic [31:0]      config_neuron_no,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      checksum
);
  localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, DONE_ST = 2'd2;
  logic [1:0] state;
  logic [wbits-1:0] w_idx, w_cnt;
  logic [nbits-1:0] n_idx, n_cnt;
  logic [31:0] layer, sext;
  logic beat, w_last, n_last, cfg_ok, accept_start, unused_bits;
  assign s_ready = state == STREAM;
  assign busy = state != IDLE;
  assign done = state == DONE_ST;
  assign beat = s_valid & s_ready;
  assign w_last = w_idx == w_cnt - wbits'(1);
  assign n_last = n_idx == n_cnt - nbits'(1);
  assign cfg_ok = (|cfg_weight_count) && (|cfg_neuron_count);
  assign accept_start = state == IDLE && start && cfg_ok;
  assign sext = {{(32 - data_bits){s_data[data_bits-1]}}, s_data[data_bits-1:0]};
  // upper input bits carry no weight information
  assign unused_bits = ^s_data[31:data_bits];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      w_idx <= '0;
      n_idx <= '0;
      w_cnt <= '0;
      n_cnt <= '0;
      layer <= '0;
      weight_valid <= 1'b0;
      weight_value <= '0;
      config_layer_no <= '0;
      config_neuron_no <= '0;
      error <= 1'b0;
    end else begin
      weight_valid <= beat;
      error <= state == IDLE && start && !cfg_ok;
      if (accept_start) begin
        state <= STREAM;
        layer <= cfg_layer_no;
        w_cnt <= cfg_weight_count;
        n_cnt <= cfg_neuron_count;
        w_idx <= '0;
        n_idx <= '0;
      end
      if (beat) begin
        weight_value <= sext;
        config_neuron_no <= 32'(n_idx);
        config_layer_no <= layer;
        w_idx <= w_last ? '0 : w_idx + wbits'(1);
        if (w_last) n_idx <= n_idx + nbits'(1);
        if (w_last && n_last) state <= DONE_ST;
      end
      if (state == DONE_ST) state <= IDLE;
    end
  end
`ifdef WEIGHT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || accept_start) checksum <= '0;
    else if (beat) checksum <= checksum + sext;
  end
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_weight_config_streamer.sv
// tb_weight_config_streamer: randomized self-checking bench against a word-list reference model.
module tb_weight_config_streamer;
  logic clk = 1'b0, reset, start, s_valid, s_ready, weight_valid, busy, done, error;
  logic [31:0] cfg_layer_no, s_data, weight_value, config_layer_no, config_neuron_no, checksum;
  logic [6:0] cfg_neuron_count;
  logic [9:0] cfg_weight_count;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;

  weight_config_streamer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_layer_no(cfg_layer_no),
    .cfg_neuron_count(cfg_neuron_count), .cfg_weight_count(cfg_weight_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .config_layer_no(config_layer_no), .config_neuron_no(config_neuron_no),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  typedef struct {logic [31:0] v; logic [31:0] n; logic [31:0] l;} beat_t;
  beat_t cap[$], exp_q[$];
  logic [31:0] wq[$];
  logic [31:0] exp_sum;
  int strobe_cyc[$];
  int done_cnt = 0, done_idx = -1, err_cnt = 0, viol = 0, cyc = 0;
  logic [63:0] prev_tags = '0;
  logic prev_rst = 1'b1;

  // bus monitor: records strobes, pulses, and tag changes without a strobe
  always @(negedge clk) begin
    cyc++;
    if (weight_valid) begin
      cap.push_back('{weight_value, config_neuron_no, config_layer_no});
      strobe_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_idx = cap.size();
    end
    if (error) err_cnt++;
    if (!reset && !prev_rst && !weight_valid && {config_layer_no, config_neuron_no} !== prev_tags) viol++;
    prev_tags = {config_layer_no, config_neuron_no};
    prev_rst = reset;
  end

  function automatic logic [31:0] sext16(input logic [31:0] w);
    return w[15] ? {16'h0, w[15:0]} - 32'h10000 : {16'h0, w[15:0]};
  endfunction

  // reference: word k of the stream goes to neuron k / nw of the layer
  task automatic build_model(input logic [31:0] layer, input int nw);
    exp_q.delete();
    exp_sum = 0;
    foreach (wq[k]) begin
      exp_q.push_back('{sext16(wq[k]), 32'(k / nw), layer});
      exp_sum += sext16(wq[k]);
    end
  endtask

  function automatic logic [31:0] cs_expect(input logic [31:0] sum);
`ifdef WEIGHT_CHECKSUM_EN
    return sum;
`else
    return 32'h0;
`endif
  endfunction

  task automatic clear_mon;
    @(posedge clk); #1;
    cap.delete();
    strobe_cyc.delete();
    done_cnt = 0;
    done_idx = -1;
    err_cnt = 0;
    viol = 0;
  endtask

  task automatic fill_words(input int cnt);
    wq.delete();
    repeat (cnt) wq.push_back($urandom);
  endtask

  // mode 0: always valid, 1: alternating, 2: random
  task automatic run_load(input logic [31:0] layer, input int nn, input int nw, input int mode,
                          input int inject_at, input int stop_after);
    int i = 0, b = 0;
    logic acc;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_layer_no = layer;
    cfg_neuron_count = 7'(nn);
    cfg_weight_count = 10'(nw);
    @(posedge clk); #1;
    start = 1'b0;
    while (i < wq.size() && i < stop_after && b < 4000) begin
      start = b == inject_at;
      cfg_layer_no = start ? 32'd5 : layer;
      s_valid = mode == 0 ? 1'b1 : mode == 1 ? (b % 2 == 0) : 1'($urandom_range(0, 1));
      s_data = s_valid ? wq[i] : $urandom;
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) i++;
      b++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (b >= 4000) begin fails++; $display("FAIL load_timeout: accepted %0d want %0d", i, wq.size()); end
  endtask

  task automatic wait_done(output bit seen);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    cfg_layer_no = '0; cfg_neuron_count = '0; cfg_weight_count = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready, weight_valid, busy, done, error} !== 5'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 00000", {s_ready, weight_valid, busy, done, error}); end
    checks++;
    if (weight_value !== 0) begin fails++; $display("FAIL reset_value: got %h want 0", weight_value); end
    checks++;
    if (config_layer_no !== 0) begin fails++; $display("FAIL reset_layer: got %h want 0", config_layer_no); end
    checks++;
    if (config_neuron_no !== 0) begin fails++; $display("FAIL reset_neuron: got %h want 0", config_neuron_no); end
    checks++;
    if (checksum !== 0) begin fails++; $display("FAIL reset_checksum: got %h want 0", checksum); end
  endtask

  task automatic test_basic;
    bit seen;
    logic b_done, r_done;
    logic [31:0] cs;
    clear_mon();
    fill_words(12);
    build_model(32'd2, 4);
    run_load(32'd2, 3, 4, 0, -1, 1 << 30);
    wait_done(seen);
    b_done = busy; r_done = s_ready; cs = checksum;
    @(negedge clk);
    checks++;
    if (!seen) begin fails++; $display("FAIL basic_done_seen: got 0 want 1"); end
    checks++;
    if ({b_done, r_done} !== 2'b10) begin fails++; $display("FAIL basic_done_busy_ready: got %b want 10", {b_done, r_done}); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    checks++;
    if (done_idx !== 12) begin fails++; $display("FAIL basic_done_with_last: got %0d want 12", done_idx); end
    checks++;
    if (cap.size() !== 12) begin fails++; $display("FAIL basic_count: got %0d want 12", cap.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= cap.size() || cap[k].v !== exp_q[k].v || cap[k].n !== exp_q[k].n || cap[k].l !== exp_q[k].l) begin
        fails++;
        $display("FAIL basic_beat%0d: got %h/%0d/%0d want %h/%0d/%0d", k, cap[k].v, cap[k].n, cap[k].l, exp_q[k].v, exp_q[k].n, exp_q[k].l);
      end
    end
    checks++;
    if (strobe_cyc.size() == 12 && strobe_cyc[11] - strobe_cyc[0] != 11) begin fails++; $display("FAIL basic_back_to_back: got span %0d want 11", strobe_cyc[11] - strobe_cyc[0]); end
    checks++;
    if (cs !== cs_expect(exp_sum)) begin fails++; $display("FAIL basic_checksum: got %h want %h", cs, cs_expect(exp_sum)); end
  endtask

  task automatic test_backpressure;
    bit seen;
    clear_mon();
    fill_words(12);
    build_model(32'd2, 4);
    run_load(32'd2, 3, 4, 1, -1, 1 << 30);
    wait_done(seen);
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || done_cnt !== 1) begin fails++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt); end
    checks++;
    if (cap.size() !== 12) begin fails++; $display("FAIL bp_count: got %0d want 12", cap.size()); end
    checks++;
    if (viol !== 0) begin fails++; $display("FAIL bp_tag_stable: got %0d changes want 0", viol); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= cap.size() || cap[k].v !== exp_q[k].v || cap[k].n !== exp_q[k].n || cap[k].l !== exp_q[k].l) begin
        fails++;
        $display("FAIL bp_beat%0d: got %h/%0d/%0d want %h/%0d/%0d", k, cap[k].v, cap[k].n, cap[k].l, exp_q[k].v, exp_q[k].n, exp_q[k].l);
      end
    end
  endtask

  task automatic test_zero_count;
    clear_mon();
    for (int z = 0; z < 2; z++) begin
      @(posedge clk); #1;
      start = 1'b1;
      cfg_layer_no = 32'd4;
      cfg_weight_count = z == 0 ? 10'd0 : 10'd4;
      cfg_neuron_count = z == 0 ? 7'd3 : 7'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({error, busy, s_ready} !== 3'b100) begin fails++; $display("FAIL zero%0d_error: got %b want 100", z, {error, busy, s_ready}); end
      @(negedge clk);
      checks++;
      if ({error, busy} !== 2'b00) begin fails++; $display("FAIL zero%0d_pulse: got %b want 00", z, {error, busy}); end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cap.size() !== 0 || err_cnt !== 2) begin fails++; $display("FAIL zero_totals: got %0d strobes %0d errors want 0 2", cap.size(), err_cnt); end
  endtask

  task automatic test_start_while_busy;
    bit seen;
    clear_mon();
    fill_words(12);
    build_model(32'd2, 4);
    run_load(32'd2, 3, 4, 2, 5, 1 << 30);
    wait_done(seen);
    repeat (5) @(negedge clk);
    checks++;
    if (!seen || done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL busy_start: got %0d done %0d error want 1 0", done_cnt, err_cnt); end
    checks++;
    if (cap.size() !== 12) begin fails++; $display("FAIL busy_count: got %0d want 12", cap.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= cap.size() || cap[k].v !== exp_q[k].v || cap[k].n !== exp_q[k].n || cap[k].l !== exp_q[k].l) begin
        fails++;
        $display("FAIL busy_beat%0d: got %h/%0d/%0d want %h/%0d/%0d", k, cap[k].v, cap[k].n, cap[k].l, exp_q[k].v, exp_q[k].n, exp_q[k].l);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    bit seen;
    logic [31:0] cs;
    clear_mon();
    fill_words(12);
    run_load(32'd7, 3, 4, 0, -1, 6);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready, weight_valid, busy, done, error} !== 5'b0 || weight_value !== 0 || config_layer_no !== 0 || config_neuron_no !== 0 || checksum !== 0) begin
      fails++;
      $display("FAIL midreset_outputs: got %b %h %h %h %h want all 0", {s_ready, weight_valid, busy, done, error}, weight_value, config_layer_no, config_neuron_no, checksum);
    end
    clear_mon();
    fill_words(1);
    build_model(32'd9, 1);
    run_load(32'd9, 1, 1, 0, -1, 1 << 30);
    wait_done(seen);
    cs = checksum;
    @(negedge clk);
    checks++;
    if (!seen || cap.size() !== 1) begin fails++; $display("FAIL midreset_reload: got %0d strobes want 1", cap.size()); end
    checks++;
    if (cap.size() == 1 && (cap[0].v !== exp_q[0].v || cap[0].n !== 0 || cap[0].l !== 9)) begin fails++; $display("FAIL midreset_beat: got %h/%0d/%0d want %h/0/9", cap[0].v, cap[0].n, cap[0].l, exp_q[0].v); end
    checks++;
    if (cs !== cs_expect(exp_sum)) begin fails++; $display("FAIL midreset_checksum: got %h want %h", cs, cs_expect(exp_sum)); end
  endtask

  task automatic test_sign_extension;
    bit seen;
    logic [31:0] cs;
    logic [31:0] want [3] = '{32'h00000005, 32'hFFFFFFFF, 32'h00007FFF};
    clear_mon();
    wq = '{32'hABCD0005, 32'h0000FFFF, 32'h00007FFF};
    run_load(32'd3, 1, 3, 0, -1, 1 << 30);
    wait_done(seen);
    cs = checksum;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= cap.size() || cap[k].v !== want[k]) begin fails++; $display("FAIL sext%0d: got %h want %h", k, cap[k].v, want[k]); end
    end
    checks++;
    if (cs !== cs_expect(32'h00008003)) begin fails++; $display("FAIL sext_checksum: got %h want %h", cs, cs_expect(32'h00008003)); end
  endtask

  task automatic test_back_to_back;
    bit seen;
    beat_t all_q[$];
    logic [31:0] layer;
    int nn, nw;
    clear_mon();
    for (int l = 0; l < 4; l++) begin
      nn = $urandom_range(1, 3);
      nw = $urandom_range(1, 5);
      layer = $urandom;
      fill_words(nn * nw);
      build_model(layer, nw);
      foreach (exp_q[k]) all_q.push_back(exp_q[k]);
      run_load(layer, nn, nw, 2, -1, 1 << 30);
      wait_done(seen);
      checks++;
      if (!seen || checksum !== cs_expect(exp_sum)) begin fails++; $display("FAIL b2b%0d_checksum: got %h want %h", l, checksum, cs_expect(exp_sum)); end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== 4 || err_cnt !== 0 || cap.size() !== all_q.size()) begin
      fails++;
      $display("FAIL b2b_totals: got %0d done %0d error %0d strobes want 4 0 %0d", done_cnt, err_cnt, cap.size(), all_q.size());
    end
    for (int k = 0; k < all_q.size(); k++) begin
      checks++;
      if (k >= cap.size() || cap[k].v !== all_q[k].v || cap[k].n !== all_q[k].n || cap[k].l !== all_q[k].l) begin
        fails++;
        $display("FAIL b2b_beat%0d: got %h/%0d/%0d want %h/%0d/%0d", k, cap[k].v, cap[k].n, cap[k].l, all_q[k].v, all_q[k].n, all_q[k].l);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid_load();
    test_sign_extension();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/weight_config_streamer.md
# weight_config_streamer

Transmit side of the neuron weight-configuration bus. Takes a flat stream of 32-bit weight words from the host/DMA side over a valid/ready handshake and drives the broadcast bus (`weight_valid`, `weight_value`, `config_layer_no`, `config_neuron_no`) that every neuron's weight memory controller snoops. One start command loads every neuron of one layer, `cfg_weight_count` words per neuron, neuron 0 first.

## Interface
- `data_bits`, 16: weight width; low `data_bits` bits of each input word are the weight.
- `max_weights`, 784: largest weight count per neuron; sets counter width `wbits = $clog2(max_weights+1)`.
- `max_neurons`, 64: largest neuron count per layer; sets `nbits = $clog2(max_neurons+1)`.
- `clk` in 1: the one clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle load command; sampled only in IDLE.
- `cfg_layer_no` in 32: target layer, latched on start.
- `cfg_neuron_count` in nbits: neurons in the layer, latched on start.
- `cfg_weight_count` in wbits: weights per neuron, latched on start.
- `s_valid` in 1: input word valid.
- `s_ready` out 1: streamer accepts a word; the beat is accepted when `s_valid & s_ready`.
- `s_data` in 32: input weight word.
- `weight_valid` out 1: bus strobe, one cycle per weight.
- `weight_value` out 32: the weight, sign-extended from `data_bits` to 32 bits.
- `config_layer_no` out 32: layer tag.
- `config_neuron_no` out 32: neuron tag, zero-extended neuron index.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle pulse after the final weight.
- `error` out 1: one-cycle pulse when a start is rejected.
- `checksum` out 32: load checksum (see Configuration).

## Operation
- States: IDLE, STREAM, DONE.
- **IDLE:** `s_ready` = 0.
  - On `start` with both counts nonzero: latch the config, clear `w_idx`/`n_idx` and the checksum, go to STREAM.
  - On `start` with either count zero: pulse `error` next cycle and stay in IDLE.
- **STREAM:** `s_ready` = 1, combinational from state. Each accepted beat:
  - registers `weight_value` = sign-extended `s_data[data_bits-1:0]` (upper input bits are ignored);
  - sets `config_neuron_no` = `n_idx` and `config_layer_no` = latched layer;
  - sets `weight_valid` = 1 for exactly one cycle.
- **Counters:** `w_idx` increments per accepted beat. At `cfg_weight_count-1` it wraps to 0 and `n_idx` increments.
- **Last beat:** the beat with `w_idx == cfg_weight_count-1` and `n_idx == cfg_neuron_count-1` moves the FSM to DONE.
- **DONE:** lasts one cycle, `done` = 1, `s_ready` = 0, then IDLE.
- **Idle beats:** cycles with `s_valid` = 0 in STREAM produce `weight_valid` = 0. The config tags hold their last value and change only together with a `weight_valid` strobe.
- **Start while not IDLE:** ignored, no error.
- **Reset mid-load:** FSM to IDLE, counters and outputs to their reset values. No partial-load flush. Receivers reset their write address on the same `reset`.
- **Counts above max:** behaviour undefined; the bench must not drive them.

## Timing
- Reset values: `s_ready` 0, `weight_valid` 0, `weight_value` 0, `config_layer_no` 0, `config_neuron_no` 0, `busy` 0, `done` 0, `error` 0, `checksum` 0.
- `start` at cycle T: STREAM and `s_ready` = 1 at T+1. `error` pulse at T+1 for a rejected start.
- Beat accepted at cycle N: `weight_valid` and the tags appear at N+1. Latency is 1 cycle, throughput is 1 weight per cycle.
- Last beat at cycle N:
  - at N+1: final `weight_valid`, `done` = 1, `busy` = 1, `s_ready` = 0;
  - at N+2: IDLE, `busy` = 0;
  - next `start` is accepted at N+2.
- `busy` = 1 from T+1 through the DONE cycle.

## Configuration
- Macro: `WEIGHT_CHECKSUM_EN`.
- **Defined:** the checksum register is cleared on an accepted start. It adds the 32-bit sign-extended `weight_value` of every accepted beat, modulo 2^32. The result is final, stable and readable from the DONE cycle until the next accepted start.
- **Undefined:** no accumulator logic, and `checksum` is tied to 0.

## Test plan
- **Basic load:** layer 2, 3 neurons × 4 weights, `s_valid` held high → 12 back-to-back `weight_valid`; `config_neuron_no` reads 0×4, 1×4, 2×4; `config_layer_no` = 2; `done` with the 12th strobe; `busy` low one cycle later.
- **Backpressure:** same load with `s_valid` alternating 1/0 → exactly 12 strobes, one per accepted beat; tags stable across gaps; value order matches input order.
- **Zero count:** `start` with `cfg_weight_count` = 0 → `error` = 1 for one cycle; no `weight_valid`, `busy` stays 0. Repeat with `cfg_neuron_count` = 0 → same result.
- **Start while busy:** second `start` (layer 5) mid-load → ignored; `config_layer_no` stays 2; single `done`.
- **Reset mid-load:** `reset` after 6 beats → all outputs 0 next cycle, `s_ready` 0; new 1×1 load completes normally.
- **Sign extension and checksum (macro on):** inputs 0xABCD0005, 0x0000FFFF, 0x00007FFF, 1×3 → `weight_value` 0x00000005, 0xFFFFFFFF, 0x00007FFF; `checksum` = 0x00008003 at DONE. Macro off → `checksum` = 0.
